seven_seg_capture: RTL and testbench
====================================

# seven_seg_capture

Recovers hex digits from a multiplexed, active-low seven-segment bus. It is the decoding counterpart of the board's hex-to-segment encoder, used to self-check display paths and to read segment streams from external display drivers. Each digit slot is glitch-filtered over a programmable stability window, its segment pattern is mapped back to a 4-bit nibble, and a full frame of `NUM_DIGITS` digits is published with a one-cycle strobe.

## Interface
- `NUM_DIGITS`, default 8: number of multiplexed digit positions (the DE2-115 has HEX0–HEX7).
- `STABLE_CYCLES`, default 4: consecutive identical samples required before a digit is accepted. Legal range is 2..255.
- `i_clk`  in  1  sole clock.
- `i_rst`  in  1  reset, synchronous and active-high.
- `i_seven`  in  7  segment pattern. Bit n drives segment n (0 = top, 1 = upper-right, 2 = lower-right, 3 = bottom, 4 = lower-left, 5 = upper-left, 6 = middle). A value of 1 means the segment is dark.
- `i_an`  in  `NUM_DIGITS`  one-hot digit select. Bit k means `i_seven` currently belongs to digit k.
- `o_value`  out  4*`NUM_DIGITS`  decoded frame. Digit k occupies bits [4k+3:4k].
- `o_blank`  out  `NUM_DIGITS`  per-digit flag: the pattern was all-dark (7'h7F).
- `o_err`  out  `NUM_DIGITS`  per-digit flag: the pattern was not a legal code.
- `o_frame_valid`  out  1  one-cycle strobe indicating that `o_value`, `o_blank` and `o_err` have just been updated.

## Operation
**Sampling**
- Each edge registers `i_seven` into `s_seven` and `i_an` into `s_an`.
- On an edge where the incoming {`i_seven`, `i_an`} differs from {`s_seven`, `s_an`}, `cnt` <= 0.
- Otherwise `cnt` <= `cnt` + 1, saturating at `STABLE_CYCLES` - 1.
- If `i_an` is not one-hot (zero bits set or several bits set), `cnt` is held at 0 and no acceptance occurs.

**Accept**
- An accept happens on the edge where `cnt` goes from `STABLE_CYCLES` - 2 to `STABLE_CYCLES` - 1.
- There is exactly one accept per stable run. A saturated `cnt` never re-accepts.
- On accept for digit k:
  - `dig[k]` <= decoded nibble.
  - `blk[k]` and `err[k]` are updated.
  - `mask[k]` <= 1.

**Decoding**
- A legal code maps to its nibble, with `blk` = 0 and `err` = 0.
- 7'h7F maps to nibble 0, with `blk` = 1.
- Any other pattern maps to nibble 0, with `err` = 1.

**Frame publication**
- If the accept makes `mask` all-ones, then on that same edge:
  - `o_value`, `o_blank` and `o_err` are loaded from the digit registers, with the new digit merged in.
  - `o_frame_valid` <= 1.
  - `mask` <= 0.
- `o_frame_valid` is 0 on every other edge.
- If a digit is accepted again before its frame completes, the latest value wins and `mask` is unchanged.
- Outputs hold their values between frames.

**Reset**
- The following all clear to 0: `o_value`, `o_blank`, `o_err`, `o_frame_valid`, `mask`, `cnt`, the digit registers and `s_an`.
- `s_seven` clears to 7'h7F.
- A reset asserted mid-frame discards any partially captured digits.

## Timing
- Take a new stable pattern whose first sampling edge is edge 0.
  - The digit is written at edge `STABLE_CYCLES` - 1.
  - If it completes a frame, `o_frame_valid` is high for the cycle following that edge.
- A pattern held for only `STABLE_CYCLES` - 1 edges is never accepted.
- Minimum frame period is `NUM_DIGITS` × `STABLE_CYCLES` cycles.
- There is no backpressure. A frame that is not consumed is overwritten by the next one.

## Structure
**Package `seven_seg_pkg`** contains:
- `SEG_BLANK` = 7'h7F.
- The 16 active-low codes, for nibbles 0–F in order: 1000000, 1111001, 0100100, 0110000, 0011001, 0010010, 0000010, 1011000, 0000000, 0010000, 0001000, 0000011, 1000110, 0100001, 0000110, 0001110.
- A typedef for the decode result: {legal, blank, nibble[3:0]}.

**Sub-module `seven_seg_inverse`** is a purely combinational mapping from pattern to decode result, instantiated once on `s_seven`.

**Top level** holds the sampling registers, the stability counter, the mask and frame logic, and the one-hot check.

## Test plan
1. **Reset.** Assert `i_rst` for 2 cycles with random inputs. Every output must be 0 and `o_frame_valid` must never pulse.
2. **Full frame.** For k = 0..7 in order, drive `i_an` = 1<<k with the code for nibble k, 4 cycles each. Expect exactly one `o_frame_valid` pulse, `o_value` = 32'h76543210, `o_blank` = 0, `o_err` = 0.
3. **Glitch rejection.** Insert a 3-cycle pulse of 7'b0000000 on digit 3 between two stable 7'b0110000 runs. The digit 3 value stays 3.
4. **Blank and invalid.** Drive digit 7 = 7'h7F and digit 2 = 7'b0111111, with the other digits legal. Expect `o_blank` = 8'h80, `o_err` = 8'h04, and both nibbles 0.
5. **Overwrite and non-one-hot.** Capture digit 0 as 3, then again as 5. Then hold `i_an` = 8'b00000011 for 10 cycles, which must be ignored. Complete the frame. Expect nibble 0 = 5 and a single strobe.
6. **Reset mid-frame.** Capture 5 digits, then pulse `i_rst`. Capture all 8 digits again. Exactly one strobe occurs, and only after the eighth post-reset accept.

Source files
------------

// File: rtl/seven_seg_pkg.sv
// seven_seg_pkg: active-low segment codes and decode result type for the capture path
package seven_seg_pkg;
    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_CODES [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1011000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };
    typedef struct packed {
        logic       legal;
        logic       blank;
        logic [3:0] nibble;
    } seg_dec_t;
endpackage

// File: rtl/seven_seg_inverse.sv
// seven_seg_inverse: maps an active-low segment pattern back to its hex nibble
module seven_seg_inverse
    import seven_seg_pkg::*;
(
    input  logic [6:0] seg,
    output seg_dec_t   dec
);
    always_comb begin
        dec = '{legal: 1'b0, blank: seg == SEG_BLANK, nibble: 4'd0};
        for (int i = 0; i < 16; i++)
            if (seg == SEG_CODES[i]) dec = '{legal: 1'b1, blank: 1'b0, nibble: 4'(i)};
    end
endmodule

// File: rtl/seven_seg_capture.sv
// seven_seg_capture: glitch-filters a multiplexed seven-segment bus and publishes decoded frames
module seven_seg_capture
    import seven_seg_pkg::*;
#(
    parameter int NUM_DIGITS    = 8,
    parameter int STABLE_CYCLES = 4
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic [6:0]              i_seven,
    input  logic [NUM_DIGITS-1:0]   i_an,
    output logic [4*NUM_DIGITS-1:0] o_value,
    output logic [NUM_DIGITS-1:0]   o_blank,
    output logic [NUM_DIGITS-1:0]   o_err,
    output logic                    o_frame_valid
);
    logic [6:0]                 s_seven;
    logic [NUM_DIGITS-1:0]      s_an, blk, err, mask, blk_n, err_n, mask_n;
    logic [NUM_DIGITS-1:0][3:0] dig, dig_n;
    logic [7:0]                 cnt;
    logic                       stable, accept, done;
    seg_dec_t                   dec;
    seven_seg_inverse u_inverse (.seg(s_seven), .dec(dec));
    assign stable = $onehot(i_an) && i_seven == s_seven && i_an == s_an;
    assign accept = stable && cnt == 8'(STABLE_CYCLES - 2);
    always_comb begin
        for (int k = 0; k < NUM_DIGITS; k++) dig_n[k] = accept && s_an[k] ? dec.nibble : dig[k];
        blk_n  = accept ? (blk & ~s_an) | (dec.blank ? s_an : '0) : blk;
        err_n  = accept ? (err & ~s_an) | (!dec.legal && !dec.blank ? s_an : '0) : err;
        mask_n = accept ? mask | s_an : mask;
    end
    assign done = accept && &mask_n;
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            s_seven       <= SEG_BLANK;
            s_an          <= '0;
            cnt           <= '0;
            dig           <= '0;
            blk           <= '0;
            err           <= '0;
            mask          <= '0;
            o_value       <= '0;
            o_blank       <= '0;
            o_err         <= '0;
            o_frame_valid <= 1'b0;
        end else begin
            s_seven       <= i_seven;
            s_an          <= i_an;
            cnt           <= !stable ? '0 : cnt == 8'(STABLE_CYCLES - 1) ? cnt : cnt + 8'd1;
            dig           <= dig_n;
            blk           <= blk_n;
            err           <= err_n;
            mask          <= done ? '0 : mask_n;
            o_frame_valid <= done;
            if (done) begin
                o_value <= dig_n;
                o_blank <= blk_n;
                o_err   <= err_n;
            end
        end
    end
endmodule

// File: tb/tb_seven_seg_capture.sv
// tb_seven_seg_capture: directed and randomized checks against a hold-duration frame model
module tb_seven_seg_capture;
    localparam int ND = 8;
    localparam int SC = 4;
    typedef struct packed {
        logic [31:0] v;
        logic [7:0]  b;
        logic [7:0]  e;
    } frame_t;
    logic        i_clk, i_rst;
    logic [6:0]  i_seven;
    logic [7:0]  i_an;
    logic [31:0] o_value;
    logic [7:0]  o_blank, o_err;
    logic        o_frame_valid;
    int          errors = 0;
    int          checks = 0;
    int          pulses = 0;
    frame_t      obs[$];
    frame_t      expq[$];
    logic [6:0]  codes [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1011000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };
    logic [31:0] m_val;
    logic [7:0]  m_blk, m_err, m_mask, p_an;
    logic [6:0]  p_seven;
    int          run;

    seven_seg_capture #(.NUM_DIGITS(ND), .STABLE_CYCLES(SC)) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_seven(i_seven), .i_an(i_an),
        .o_value(o_value), .o_blank(o_blank), .o_err(o_err), .o_frame_valid(o_frame_valid)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    always @(negedge i_clk) begin
        if (o_frame_valid === 1'b1) begin
            pulses++;
            obs.push_back('{o_value, o_blank, o_err});
        end
    end

    task automatic model_accept(input logic [6:0] s, input logic [7:0] a);
        int k = 0;
        logic [3:0] nib = 4'd0;
        logic bl = 1'b0;
        logic er = 1'b1;
        for (int i = 0; i < ND; i++) if (a[i]) k = i;
        if (s == 7'h7F) begin
            bl = 1'b1;
            er = 1'b0;
        end
        for (int i = 0; i < 16; i++) if (codes[i] == s) begin
            nib = 4'(i);
            er = 1'b0;
        end
        m_val[4*k +: 4] = nib;
        m_blk[k] = bl;
        m_err[k] = er;
        m_mask[k] = 1'b1;
        if (&m_mask) begin
            expq.push_back('{m_val, m_blk, m_err});
            m_mask = '0;
        end
    endtask

    task automatic hold(input logic [6:0] s, input logic [7:0] a, input int n);
        int old;
        i_seven = s;
        i_an = a;
        old = (s == p_seven && a == p_an) ? run : 0;
        run = old + n;
        p_seven = s;
        p_an = a;
        if ($countones(a) == 1 && old < SC && run >= SC) model_accept(s, a);
        repeat (n) @(posedge i_clk);
        #1;
    endtask

    task automatic put_digit(input int k, input int nib);
        hold(codes[nib], 8'(1 << k), SC);
    endtask

    task automatic settle();
        hold(7'h7F, 8'h00, 2);
    endtask

    task automatic pulse_reset(input int n);
        i_rst = 1'b1;
        i_seven = 7'($urandom);
        i_an = 8'($urandom);
        repeat (n) @(posedge i_clk);
        #1;
        i_seven = 7'h7F;
        i_an = '0;
        i_rst = 1'b0;
        m_val = '0;
        m_blk = '0;
        m_err = '0;
        m_mask = '0;
        p_seven = 7'h7F;
        p_an = '0;
        run = 0;
    endtask

    task automatic test_reset();
        int p0 = pulses;
        pulse_reset(2);
        checks += 5;
        if (o_value !== 32'h0) begin errors++; $display("FAIL reset_value: got %h expected 0", o_value); end
        if (o_blank !== 8'h0) begin errors++; $display("FAIL reset_blank: got %h expected 0", o_blank); end
        if (o_err !== 8'h0) begin errors++; $display("FAIL reset_err: got %h expected 0", o_err); end
        if (o_frame_valid !== 1'b0) begin errors++; $display("FAIL reset_fv: got %b expected 0", o_frame_valid); end
        if (pulses != p0) begin errors++; $display("FAIL reset_pulse: got %0d expected 0", pulses - p0); end
    endtask

    task automatic test_full_frame();
        int p0 = pulses;
        for (int k = 0; k < ND; k++) put_digit(k, k);
        settle();
        checks += 4;
        if (pulses - p0 != 1) begin errors++; $display("FAIL full_pulses: got %0d expected 1", pulses - p0); end
        if (o_value !== 32'h76543210) begin errors++; $display("FAIL full_value: got %h expected 76543210", o_value); end
        if (o_blank !== 8'h0) begin errors++; $display("FAIL full_blank: got %h expected 0", o_blank); end
        if (o_err !== 8'h0) begin errors++; $display("FAIL full_err: got %h expected 0", o_err); end
    endtask

    task automatic test_glitch();
        int p0 = pulses;
        for (int k = 0; k < ND; k++) if (k != 3) put_digit(k, $urandom_range(0, 15));
        put_digit(3, 3);
        for (int k = 0; k < ND; k++) if (k != 3) put_digit(k, $urandom_range(0, 15));
        hold(7'b0000000, 8'h08, SC - 1);
        put_digit(3, 3);
        settle();
        checks += 2;
        if (pulses - p0 != 2) begin errors++; $display("FAIL glitch_pulses: got %0d expected 2", pulses - p0); end
        if (o_value[15:12] !== 4'h3) begin errors++; $display("FAIL glitch_digit3: got %h expected 3", o_value[15:12]); end
    endtask

    task automatic test_blank_invalid();
        int p0 = pulses;
        int n5 = $urandom_range(1, 15);
        for (int k = 0; k < ND; k++)
            if (k == 7) hold(7'h7F, 8'h80, SC);
            else if (k == 2) hold(7'b0111111, 8'h04, SC);
            else put_digit(k, k == 5 ? n5 : $urandom_range(0, 15));
        settle();
        checks += 6;
        if (pulses - p0 != 1) begin errors++; $display("FAIL blank_pulses: got %0d expected 1", pulses - p0); end
        if (o_blank !== 8'h80) begin errors++; $display("FAIL blank_flags: got %h expected 80", o_blank); end
        if (o_err !== 8'h04) begin errors++; $display("FAIL err_flags: got %h expected 04", o_err); end
        if (o_value[31:28] !== 4'h0) begin errors++; $display("FAIL blank_nibble: got %h expected 0", o_value[31:28]); end
        if (o_value[11:8] !== 4'h0) begin errors++; $display("FAIL err_nibble: got %h expected 0", o_value[11:8]); end
        if (o_value[23:20] !== 4'(n5)) begin errors++; $display("FAIL legal_nibble: got %h expected %h", o_value[23:20], n5); end
    endtask

    task automatic test_overwrite();
        int p0 = pulses;
        put_digit(0, 3);
        put_digit(0, 5);
        hold(7'($urandom), 8'b00000011, 10);
        for (int k = 1; k < ND; k++) put_digit(k, $urandom_range(0, 15));
        settle();
        checks += 2;
        if (pulses - p0 != 1) begin errors++; $display("FAIL overwrite_pulses: got %0d expected 1", pulses - p0); end
        if (o_value[3:0] !== 4'h5) begin errors++; $display("FAIL overwrite_digit0: got %h expected 5", o_value[3:0]); end
    endtask

    task automatic test_reset_mid();
        int p0 = pulses;
        for (int k = 0; k < 5; k++) put_digit(k, 1);
        pulse_reset(1);
        for (int k = 0; k < ND - 1; k++) put_digit(k, k + 8);
        settle();
        checks++;
        if (pulses != p0) begin errors++; $display("FAIL rstmid_early: got %0d expected 0", pulses - p0); end
        put_digit(ND - 1, 15);
        settle();
        checks += 2;
        if (pulses - p0 != 1) begin errors++; $display("FAIL rstmid_pulses: got %0d expected 1", pulses - p0); end
        if (o_value !== 32'hFEDCBA98) begin errors++; $display("FAIL rstmid_value: got %h expected fedcba98", o_value); end
    endtask

    task automatic test_random();
        for (int t = 0; t < 300; t++) begin
            logic [6:0] s;
            logic [7:0] a;
            int r = $urandom_range(0, 9);
            int q = $urandom_range(0, 5);
            a = r < 8 ? 8'(1 << $urandom_range(0, 7)) : r == 8 ? 8'h00 : 8'($urandom);
            s = q < 4 ? codes[$urandom_range(0, 15)] : q == 4 ? 7'h7F : 7'($urandom);
            if ($urandom_range(0, 4) == 0) begin
                s = p_seven;
                a = p_an;
            end
            hold(s, a, $urandom_range(1, 6));
        end
        settle();
        checks++;
        if (obs.size() != expq.size())
            begin errors++; $display("FAIL rand_frames: got %0d expected %0d", obs.size(), expq.size()); end
        for (int i = 0; i < obs.size() && i < expq.size(); i++) begin
            checks++;
            if (obs[i] !== expq[i])
                begin errors++; $display("FAIL rand_frame%0d: got %h expected %h", i, obs[i], expq[i]); end
        end
    endtask

    initial begin
        i_rst = 1'b1;
        i_seven = 7'h7F;
        i_an = '0;
        test_reset();
        test_full_frame();
        test_glitch();
        test_blank_invalid();
        test_overwrite();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
